// File: rtl/fp32_floor.sv
// Two-stage pipelined binary32 floor: z = largest integral float <= a.
// Define FP32_FLOOR_FLAGS_EN to add registered inexact/invalid outputs aligned with z.
module fp32_floor (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  output logic [31:0] z
`ifdef FP32_FLOOR_FLAGS_EN
  ,
  output logic        inexact,
  output logic        invalid
`endif
);

  logic [31:0] a_q;

  always_ff @(posedge clk) begin
    if (rst) a_q <= '0;
    else     a_q <= a;
  end

  logic        s;
  logic [7:0]  e;
  logic [22:0] m;

  assign s = a_q[31];
  assign e = a_q[30:23];
  assign m = a_q[22:0];

  logic is_special;
  logic is_zero;
  logic is_small;
  logic is_integral;

  assign is_special  = (e == 8'hFF);
  assign is_zero     = (a_q[30:0] == 31'd0);
  assign is_small    = (e < 8'd127);
  assign is_integral = (e >= 8'd150);

  // k = 23 - E fractional bits; only meaningful when 127 <= e <= 149 (k = 1..23).
  logic [4:0]  k;
  logic [30:0] frac_mask;
  logic [30:0] trunc_mag;
  logic [30:0] unit_mag;
  logic        has_frac;

  assign k         = 5'(8'd150 - e);
  assign frac_mask = ~(31'h7FFF_FFFF << k);
  assign trunc_mag = a_q[30:0] & ~frac_mask;
  assign unit_mag  = 31'd1 << k;
  assign has_frac  = |(a_q[30:0] & frac_mask);

  logic [31:0] floor_d;

  always_comb begin
    floor_d = a_q;
    if (is_special) begin
      if (m != 23'd0) floor_d = a_q | 32'h0040_0000;
    end else if (is_zero) begin
      floor_d = a_q;
    end else if (is_small) begin
      floor_d = s ? 32'hBF80_0000 : 32'h0000_0000;
    end else if (is_integral) begin
      floor_d = a_q;
    end else if (s && has_frac) begin
      // Carry out of the mantissa lands in the exponent field, e.g. -1.5 -> -2.0.
      floor_d = {s, trunc_mag + unit_mag};
    end else begin
      floor_d = {s, trunc_mag};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) z <= '0;
    else     z <= floor_d;
  end

`ifdef FP32_FLOOR_FLAGS_EN
  logic inexact_d;
  logic invalid_d;

  always_comb begin
    inexact_d = 1'b0;
    invalid_d = 1'b0;
    if (is_special) begin
      invalid_d = (m != 23'd0) && !m[22];
    end else if (!is_zero && !is_integral) begin
      inexact_d = is_small ? 1'b1 : has_frac;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inexact <= 1'b0;
      invalid <= 1'b0;
    end else begin
      inexact <= inexact_d;
      invalid <= invalid_d;
    end
  end
`endif

endmodule

// File: tb/tb_fp32_floor.sv
// Self-checking bench for fp32_floor: directed vectors, random streaming and mid-stream reset,
// with an expected-value queue filled on drive and drained as z is produced.
module tb_fp32_floor;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] z;
`ifdef FP32_FLOOR_FLAGS_EN
  logic        inexact;
  logic        invalid;
  logic [1:0]  exp_f_q[$];
`endif

  logic [31:0] exp_q[$];
  int          n_compared;
  int          n_failed;

  fp32_floor dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .z(z)
`ifdef FP32_FLOOR_FLAGS_EN
    ,
    .inexact(inexact),
    .invalid(invalid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference floor built from integer arithmetic on the significand, then renormalised.
  function automatic logic [31:0] ref_floor(input logic [31:0] v);
    logic   sg;
    int     ex;
    longint sig;
    longint n;
    int     sh;
    int     p;
    sg = v[31];
    ex = int'(v[30:23]) - 127;
    if (v[30:23] == 8'hFF) return (v[22:0] != 23'd0) ? (v | 32'h0040_0000) : v;
    if (v[30:0] == 31'd0) return v;
    if (ex < 0) return sg ? 32'hBF80_0000 : 32'h0000_0000;
    if (ex >= 23) return v;
    sig = longint'({1'b1, v[22:0]});
    sh  = 23 - ex;
    n   = sig >> sh;
    if (sg && ((sig & ((64'sd1 <<< sh) - 1)) != 0)) n = n + 1;
    p = 0;
    for (int i = 0; i < 25; i++) if (((n >> i) & 1) != 0) p = i;
    return {sg, 8'(127 + p), 23'((n << (23 - p)) & 64'h7F_FFFF)};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [7:0]  ex;
    logic [22:0] mt;
    mt = 23'($urandom);
    case ($urandom_range(0, 9))
      0:       ex = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'hFF;
      1:       ex = 8'($urandom_range(0, 126));
      default: ex = 8'($urandom_range(120, 160));
    endcase
    if ($urandom_range(0, 3) == 0) mt = mt & 23'h7F_FF00;
    return {1'($urandom), ex, mt};
  endfunction

  // Drives one cycle; the expected z for that operand is queued. A reset cycle flushes the
  // queue: z is 0 right after the reset edge and 0 again on the following edge.
  task automatic drive(input logic r, input logic [31:0] v, input logic [31:0] expv);
    @(negedge clk);
    rst = r;
    a   = v;
    if (r) begin
      exp_q.delete();
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
`ifdef FP32_FLOOR_FLAGS_EN
      exp_f_q.delete();
      exp_f_q.push_back(2'b00);
      exp_f_q.push_back(2'b00);
`endif
    end else begin
      exp_q.push_back(expv);
`ifdef FP32_FLOOR_FLAGS_EN
      exp_f_q.push_back({(v[30:23] != 8'hFF) && (expv != v),
                         (v[30:23] == 8'hFF) && (v[22:0] != 23'd0) && !v[22]});
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] expv;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3FC0_0000, 32'd0);
      expv = exp_q.pop_front();
      n_compared++;
      if (z !== expv) begin
        n_failed++;
        $display("FAIL reset[%0d]: z=%08h expected %08h", i, z, expv);
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] vin [14];
    logic [31:0] vexp[14];
    logic [31:0] expv;
    vin = '{32'h3FC0_0000, 32'h3F00_0000, 32'hBFC0_0000, 32'hC0F0_0001, 32'hBF7F_FFFF,
            32'h8000_0001, 32'h8000_0000, 32'h0000_0001, 32'h4B00_0001, 32'hC000_0000,
            32'h7F80_0000, 32'h7FA0_0000, 32'hC0E0_0000, 32'h4B7F_FFFF};
    vexp = '{32'h3F80_0000, 32'h0000_0000, 32'hC000_0000, 32'hC100_0000, 32'hBF80_0000,
             32'hBF80_0000, 32'h8000_0000, 32'h0000_0000, 32'h4B00_0001, 32'hC000_0000,
             32'h7F80_0000, 32'h7FE0_0000, 32'hC0E0_0000, 32'h4B7F_FFFF};
    for (int i = 0; i < 14 + 2; i++) begin
      if (i < 14) drive(1'b0, vin[i], vexp[i]);
      else        drive(1'b0, 32'h0000_0000, 32'h0000_0000);
      if (exp_q.size() == 0) begin
        n_compared++;
        n_failed++;
        $display("FAIL directed[%0d]: expected queue empty", i);
        continue;
      end
      expv = exp_q.pop_front();
      n_compared++;
      if (z !== expv) begin
        n_failed++;
        $display("FAIL directed[%0d]: z=%08h expected %08h", i, z, expv);
      end
`ifdef FP32_FLOOR_FLAGS_EN
      begin
        logic [1:0] ef;
        ef = exp_f_q.pop_front();
        n_compared++;
        if ({inexact, invalid} !== ef) begin
          n_failed++;
          $display("FAIL directed_flags[%0d]: inexact,invalid=%b%b expected %b", i, inexact, invalid, ef);
        end
      end
`endif
    end
  endtask

  task automatic test_stream(input int cycles);
    logic [31:0] v;
    logic [31:0] expv;
    for (int i = 0; i < cycles; i++) begin
      v = rand_operand();
      drive(1'b0, v, ref_floor(v));
      if (exp_q.size() == 0) begin
        n_compared++;
        n_failed++;
        $display("FAIL stream[%0d]: expected queue empty", i);
        continue;
      end
      expv = exp_q.pop_front();
      n_compared++;
      if (z !== expv) begin
        n_failed++;
        $display("FAIL stream[%0d]: z=%08h expected %08h", i, z, expv);
      end
`ifdef FP32_FLOOR_FLAGS_EN
      begin
        logic [1:0] ef;
        ef = exp_f_q.pop_front();
        n_compared++;
        if ({inexact, invalid} !== ef) begin
          n_failed++;
          $display("FAIL stream_flags[%0d]: inexact,invalid=%b%b expected %b", i, inexact, invalid, ef);
        end
      end
`endif
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] v;
    logic [31:0] expv;
    for (int i = 0; i < 14; i++) begin
      v = (i < 6) ? 32'hBFC0_0000 + 32'(i) : rand_operand();
      drive(i == 6, v, ref_floor(v));
      expv = exp_q.pop_front();
      if (exp_q.size() > 0 && i == 6) expv = 32'd0;
      n_compared++;
      if (z !== expv) begin
        n_failed++;
        $display("FAIL reset_midstream[%0d]: z=%08h expected %08h", i, z, expv);
      end
`ifdef FP32_FLOOR_FLAGS_EN
      begin
        logic [1:0] ef;
        ef = exp_f_q.pop_front();
        n_compared++;
        if ({inexact, invalid} !== ef) begin
          n_failed++;
          $display("FAIL reset_midstream_flags[%0d]: inexact,invalid=%b%b expected %b", i, inexact, invalid, ef);
        end
      end
`endif
    end
  endtask

  initial begin
    n_compared = 0;
    n_failed   = 0;
    rst        = 1'b1;
    a          = 32'd0;
    test_reset();
    test_directed();
    test_stream(450);
    test_reset_midstream();
    test_stream(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
